// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller: tracks destination registers through EX/MEM/WB,
// drives the EX operand forwarding selects and the load-use stall.
module hazard_fwd_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wen;
    logic       is_load;
  } rec_t;

  // The load flag is irrelevant once a producer has reached WB.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       wen;
  } wb_rec_t;

  rec_t    r_ex, r_mem;
  wb_rec_t r_wb;

  logic       w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_wb_a, w_wb_b;
  logic       w_load;
  logic [1:0] w_sel_a, w_sel_b;

  function automatic logic hit(input logic v, input logic w, input logic [4:0] d,
                               input logic [4:0] r, input logic u);
    return v && w && (d == r) && (r != 5'd0) && u;
  endfunction

  always_comb begin
    w_ex_a  = hit(r_ex.valid,  r_ex.wen,  r_ex.dest,  id_rs, id_use_rs);
    w_ex_b  = hit(r_ex.valid,  r_ex.wen,  r_ex.dest,  id_rt, id_use_rt);
    w_mem_a = hit(r_mem.valid, r_mem.wen, r_mem.dest, id_rs, id_use_rs);
    w_mem_b = hit(r_mem.valid, r_mem.wen, r_mem.dest, id_rt, id_use_rt);
    w_wb_a  = hit(r_wb.valid,  r_wb.wen,  r_wb.dest,  id_rs, id_use_rs);
    w_wb_b  = hit(r_wb.valid,  r_wb.wen,  r_wb.dest,  id_rt, id_use_rt);
  end

  assign stall  = id_valid & ~flush & r_ex.is_load & (w_ex_a | w_ex_b);
  assign w_load = id_valid & ~stall & ~flush;

  // Youngest producer wins; the select names where the value sits once the
  // consumer has moved into EX, one stage further down than now.
  always_comb begin
    w_sel_a = 2'd0;
    if (w_ex_a)       w_sel_a = 2'd1;
    else if (w_mem_a) w_sel_a = 2'd2;
    else if (w_wb_a)  w_sel_a = 2'd3;
    w_sel_b = 2'd0;
    if (w_ex_b)       w_sel_b = 2'd1;
    else if (w_mem_b) w_sel_b = 2'd2;
    else if (w_wb_b)  w_sel_b = 2'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex      <= '0;
      r_mem     <= '0;
      r_wb      <= '0;
      fwd_a_sel <= 2'd0;
      fwd_b_sel <= 2'd0;
      stall_cnt <= '0;
    end else begin
      r_mem <= r_ex;
      r_wb  <= '{valid: r_mem.valid, dest: r_mem.dest, wen: r_mem.wen};
      if (w_load) begin
        r_ex      <= '{valid: 1'b1, dest: id_dest, wen: id_wen, is_load: id_is_load};
        fwd_a_sel <= w_sel_a;
        fwd_b_sel <= w_sel_b;
      end else begin
        r_ex      <= '0;
        fwd_a_sel <= 2'd0;
        fwd_b_sel <= 2'd0;
      end
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: stimulus pushes per-cycle expected outputs,
// a monitor pops and compares them at the falling edge.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs, id_use_rt, id_wen, id_is_load, flush;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [3:0] stall_cnt;

  hazard_fwd_unit #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_wen(id_wen),
    .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       st;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] c;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   sid   = 0;
  event chk_ev;

  always begin
    @(negedge clk or chk_ev);
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      total++;
      if (e.st !== stall || e.a !== fwd_a_sel || e.b !== fwd_b_sel || e.c !== stall_cnt) begin
        bad++;
        $display("FAIL step%0d: got stall=%0b a=%0d b=%0d cnt=%0d, want stall=%0b a=%0d b=%0d cnt=%0d",
                 e.id, stall, fwd_a_sel, fwd_b_sel, stall_cnt, e.st, e.a, e.b, e.c);
      end
    end
  end

  task automatic drv(input logic v, input logic [4:0] s, input logic [4:0] t,
                     input logic us, input logic ut, input logic [4:0] d,
                     input logic w, input logic ld, input logic fl);
    id_valid = v; id_rs = s; id_rt = t; id_use_rs = us; id_use_rt = ut;
    id_dest = d; id_wen = w; id_is_load = ld; flush = fl;
  endtask

  task automatic nop();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                     input logic fl);
    drv(1'b1, s, t, 1'b1, 1'b1, d, 1'b1, 1'b0, fl);
  endtask

  task automatic lw(input logic [4:0] d, input logic [4:0] s);
    drv(1'b1, s, 5'd0, 1'b1, 1'b0, d, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic push(input logic es, input logic [1:0] ea, input logic [1:0] eb,
                      input logic [3:0] ec);
    exp_t e;
    e.id = sid; e.st = es; e.a = ea; e.b = eb; e.c = ec;
    sbq.push_back(e);
    sid++;
  endtask

  // Expected outputs for the current cycle, then advance one clock.
  task automatic chk(input logic es, input logic [1:0] ea, input logic [1:0] eb,
                     input logic [3:0] ec);
    push(es, ea, eb, ec);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] c;
    rst_n = 1'b0;
    lw(5'd8, 5'd1);
    #3;
    push(1'b0, 2'd0, 2'd0, 4'd0);
    ->chk_ev;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back, one-gap and two-gap ALU dependencies
    alu(5'd3, 5'd1, 5'd2, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd0);
    alu(5'd4, 5'd3, 5'd5, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd0);
    nop();                         chk(1'b0, 2'd1, 2'd0, 4'd0);
    alu(5'd3, 5'd1, 5'd2, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd0);
    alu(5'd10, 5'd11, 5'd12, 1'b0); chk(1'b0, 2'd0, 2'd0, 4'd0);
    alu(5'd4, 5'd3, 5'd5, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd0);
    nop();                         chk(1'b0, 2'd2, 2'd0, 4'd0);
    alu(5'd3, 5'd1, 5'd2, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd0);
    alu(5'd10, 5'd11, 5'd12, 1'b0); chk(1'b0, 2'd0, 2'd0, 4'd0);
    alu(5'd13, 5'd14, 5'd15, 1'b0); chk(1'b0, 2'd0, 2'd0, 4'd0);
    alu(5'd4, 5'd3, 5'd5, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd0);
    nop();                         chk(1'b0, 2'd3, 2'd0, 4'd0);
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd0);

    // Load-use: one stall, bubble, then MEM forwarding on both operands
    lw(5'd8, 5'd1);                chk(1'b0, 2'd0, 2'd0, 4'd0);
    alu(5'd9, 5'd8, 5'd8, 1'b0);   chk(1'b1, 2'd0, 2'd0, 4'd0);
    alu(5'd9, 5'd8, 5'd8, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd1);
    nop();                         chk(1'b0, 2'd2, 2'd2, 4'd1);
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd1);

    // Register 0 never forwards or stalls
    alu(5'd0, 5'd1, 5'd2, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd1);
    alu(5'd5, 5'd0, 5'd0, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd1);
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd1);
    lw(5'd0, 5'd1);                chk(1'b0, 2'd0, 2'd0, 4'd1);
    alu(5'd6, 5'd0, 5'd0, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd1);
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd1);
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd1);

    // Youngest of two $7 writers wins; unused rt ignored
    alu(5'd7, 5'd1, 5'd2, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd1);
    alu(5'd7, 5'd1, 5'd2, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd1);
    alu(5'd11, 5'd7, 5'd7, 1'b0);  chk(1'b0, 2'd0, 2'd0, 4'd1);
    nop();                         chk(1'b0, 2'd1, 2'd1, 4'd1);
    lw(5'd12, 5'd1);               chk(1'b0, 2'd0, 2'd0, 4'd1);
    drv(1'b1, 5'd13, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
                                   chk(1'b0, 2'd0, 2'd0, 4'd1);
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd1);
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd1);

    // Flush beats load-use stall and kills forwarding
    lw(5'd8, 5'd1);                chk(1'b0, 2'd0, 2'd0, 4'd1);
    alu(5'd9, 5'd8, 5'd8, 1'b1);   chk(1'b0, 2'd0, 2'd0, 4'd1);
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd1);
    alu(5'd3, 5'd1, 5'd2, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd1);
    alu(5'd4, 5'd3, 5'd5, 1'b1);   chk(1'b0, 2'd0, 2'd0, 4'd1);
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd1);
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd1);

    // Consecutive load-use pairs drive the counter into saturation
    c = 4'd1;
    for (int i = 0; i < 16; i++) begin
      lw(5'd8, 5'd1);
      if (i == 0) chk(1'b0, 2'd0, 2'd0, c);
      else        chk(1'b0, 2'd2, 2'd2, c);
      alu(5'd9, 5'd8, 5'd8, 1'b0); chk(1'b1, 2'd0, 2'd0, c);
      if (c != 4'd15) c = c + 4'd1;
      alu(5'd9, 5'd8, 5'd8, 1'b0); chk(1'b0, 2'd0, 2'd0, c);
    end

    // Asynchronous reset while stalled
    lw(5'd8, 5'd1);                chk(1'b0, 2'd2, 2'd2, 4'd15);
    alu(5'd9, 5'd8, 5'd8, 1'b0);
    push(1'b1, 2'd0, 2'd0, 4'd15);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    push(1'b0, 2'd0, 2'd0, 4'd0);
    #1;
    ->chk_ev;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd0);
    alu(5'd3, 5'd1, 5'd2, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd0);
    alu(5'd4, 5'd3, 5'd5, 1'b0);   chk(1'b0, 2'd0, 2'd0, 4'd0);
    nop();                         chk(1'b0, 2'd1, 2'd0, 4'd0);
    nop();                         chk(1'b0, 2'd0, 2'd0, 4'd0);

    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
